// File: rtl/imm_ext_pkg.sv
// rtl/imm_ext_pkg.sv - shared mode encodings and FIFO depth for the immediate extender
package imm_ext_pkg;

    typedef enum logic [1:0] {
        MODE_ZERO  = 2'd0,
        MODE_SIGN  = 2'd1,
        MODE_UPPER = 2'd2,
        MODE_BYTE  = 2'd3
    } imm_mode_e;

    localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/imm_ext_pipe_if.sv
// rtl/imm_ext_pipe_if.sv - producer/consumer handshake bundle for imm_ext_pipe
interface imm_ext_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_err;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/imm_ext_skid_fifo.sv
// rtl/imm_ext_skid_fifo.sv - 2-entry skid FIFO with registered in_ready and flush
module imm_ext_skid_fifo
    import imm_ext_pkg::*;
#(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    localparam logic [1:0] DEPTH_C = 2'(FIFO_DEPTH);

    logic [W-1:0] mem [FIFO_DEPTH];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic [1:0]   count_next;
    logic         push;
    logic         pop;

    assign push      = in_valid & in_ready & ~flush;
    assign out_valid = (count != 2'd0);
    assign pop       = out_valid & out_ready;
    assign out_data  = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 2'd1;
        end else if (pop && !push) begin
            count_next = count - 2'd1;
        end
    end

    // in_ready is registered from the post-update occupancy so it never depends on out_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            in_ready <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            count    <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            in_ready <= 1'b1;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count    <= count_next;
            in_ready <= (count_next < DEPTH_C);
        end
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// rtl/imm_ext_pipe.sv - immediate extender feeding a 2-entry skid FIFO; IMM_EXT_UPPER_EN enables mode 2
module imm_ext_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    imm_ext_pipe_if.slave  bus
);
    logic [OUT_W-1:0] ext_data;
    logic             ext_err;
    logic [OUT_W:0]   fifo_dout;

    // Extension happens at push time so stored entries ignore later mode changes
    always_comb begin
        ext_data = '0;
        ext_err  = 1'b0;
        case (imm_mode_e'(bus.in_mode))
            MODE_ZERO:  ext_data = OUT_W'(bus.in_data);
            MODE_SIGN:  ext_data = OUT_W'($signed(bus.in_data));
`ifdef IMM_EXT_UPPER_EN
            MODE_UPPER: ext_data = OUT_W'(bus.in_data) << (OUT_W - IN_W);
`else
            MODE_UPPER: ext_err = 1'b1;
`endif
            MODE_BYTE:  ext_data = OUT_W'($signed(bus.in_data[7:0]));
            default:    ext_err = 1'b1;
        endcase
    end

    imm_ext_skid_fifo #(
        .W(OUT_W + 1)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   ({ext_err, ext_data}),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (fifo_dout)
    );

    assign bus.out_data = fifo_dout[OUT_W-1:0];
    assign bus.out_err  = fifo_dout[OUT_W];

endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb/tb_imm_ext_pipe.sv - directed table-driven bench for imm_ext_pipe
module tb_imm_ext_pipe;
    import imm_ext_pkg::*;

    localparam int IN_W  = 16;
    localparam int OUT_W = 32;

    typedef struct {
        logic [1:0]       mode;
        logic [IN_W-1:0]  data;
        logic [OUT_W-1:0] exp_data;
        logic             exp_err;
    } vec_t;

    logic clk;
    logic rst_n;
    logic flush;
    int   n_checks;
    int   n_fail;
    vec_t vecs [8];

    imm_ext_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    imm_ext_pipe #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [IN_W-1:0] d);
        bus.in_valid = v;
        bus.in_mode  = m;
        bus.in_data  = d;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        vecs[0] = '{MODE_SIGN,  16'h8004, 32'hFFFF8004, 1'b0};
        vecs[1] = '{MODE_ZERO,  16'h8004, 32'h00008004, 1'b0};
        vecs[2] = '{MODE_BYTE,  16'h0080, 32'hFFFFFF80, 1'b0};
        vecs[3] = '{MODE_BYTE,  16'h127F, 32'h0000007F, 1'b0};
        vecs[4] = '{MODE_SIGN,  16'h7FFF, 32'h00007FFF, 1'b0};
        vecs[5] = '{MODE_ZERO,  16'hFFFF, 32'h0000FFFF, 1'b0};
`ifdef IMM_EXT_UPPER_EN
        vecs[6] = '{MODE_UPPER, 16'h1234, 32'h12340000, 1'b0};
        vecs[7] = '{MODE_UPPER, 16'hFFFF, 32'hFFFF0000, 1'b0};
`else
        vecs[6] = '{MODE_UPPER, 16'h1234, 32'h00000000, 1'b1};
        vecs[7] = '{MODE_UPPER, 16'hFFFF, 32'h00000000, 1'b1};
`endif

        rst_n = 1'b0;
        flush = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, 2'd0, '0);

        // reset state
        #12;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
        chk("rst_out_data",  64'(bus.out_data),  64'd0);
        chk("rst_out_err",   64'(bus.out_err),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready_before_edge", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        chk("rel_in_ready_after_edge", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        chk("empty_pop_ignored", 64'(bus.out_valid), 64'd0);

        // back-to-back table traffic at full rate, one result per cycle
        drive(1'b1, vecs[0].mode, vecs[0].data);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), 64'(bus.out_valid), 64'd1);
            chk($sformatf("vec%0d_data", i),  64'(bus.out_data),  64'(vecs[i].exp_data));
            chk($sformatf("vec%0d_err", i),   64'(bus.out_err),   64'(vecs[i].exp_err));
            chk($sformatf("vec%0d_ready", i), 64'(bus.in_ready),  64'd1);
            if (i < 7) drive(1'b1, vecs[i+1].mode, vecs[i+1].data);
            else       drive(1'b0, 2'd0, '0);
        end
        @(negedge clk);
        chk("drain_empty", 64'(bus.out_valid), 64'd0);

        // backpressure: three pushes with consumer stalled
        bus.out_ready = 1'b0;
        drive(1'b1, MODE_ZERO, 16'h0011);
        @(negedge clk);
        drive(1'b1, MODE_ZERO, 16'h0022);
        @(negedge clk);
        drive(1'b1, MODE_SIGN, 16'h0033);
        chk("bp_full_ready", 64'(bus.in_ready), 64'd0);
        chk("bp_head_a", 64'(bus.out_data), 64'h11);
        @(negedge clk);
        chk("bp_hold_ready", 64'(bus.in_ready), 64'd0);
        chk("bp_stable_a", 64'(bus.out_data), 64'h11);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_pop_b", 64'(bus.out_data), 64'h22);
        chk("bp_ready_back", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        drive(1'b0, 2'd0, '0);
        chk("bp_pop_c_valid", 64'(bus.out_valid), 64'd1);
        chk("bp_pop_c", 64'(bus.out_data), 64'h33);
        @(negedge clk);
        chk("bp_empty", 64'(bus.out_valid), 64'd0);

        // flush while full drops the concurrent push
        bus.out_ready = 1'b0;
        drive(1'b1, MODE_ZERO, 16'h00AA);
        @(negedge clk);
        drive(1'b1, MODE_ZERO, 16'h00BB);
        @(negedge clk);
        chk("fl_full", 64'(bus.in_ready), 64'd0);
        flush = 1'b1;
        drive(1'b1, MODE_ZERO, 16'h00CC);
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, 2'd0, '0);
        chk("fl_out_valid", 64'(bus.out_valid), 64'd0);
        chk("fl_in_ready",  64'(bus.in_ready),  64'd1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("fl_dropped_1", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        chk("fl_dropped_2", 64'(bus.out_valid), 64'd0);

        // asynchronous reset mid-stream
        bus.out_ready = 1'b0;
        drive(1'b1, MODE_SIGN, 16'h8001);
        @(negedge clk);
        drive(1'b0, 2'd0, '0);
        chk("ar_pre_valid", 64'(bus.out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", 64'(bus.out_valid), 64'd0);
        chk("ar_in_ready",  64'(bus.in_ready),  64'd0);
        chk("ar_out_data",  64'(bus.out_data),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_ready_after", 64'(bus.in_ready), 64'd1);
        chk("ar_lost", 64'(bus.out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_ext_pipe.md
IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 16, immediate input width (legal 8..32).
REQ-002 SHALL have parameter OUT_W, default 32, extended output width (legal IN_W..64).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port flush  input  1  synchronous discard of all buffered entries.
REQ-006 SHALL have port in_valid  input  1  producer offers an immediate.
REQ-007 SHALL have port in_ready  output  1  block accepts the immediate this cycle.
REQ-008 SHALL have port in_data  input  IN_W  raw immediate field.
REQ-009 SHALL have port in_mode  input  2  extension mode (see Function).
REQ-010 SHALL have port out_valid  output  1  out_data/out_err hold a result.
REQ-011 SHALL have port out_ready  input  1  consumer takes the result this cycle.
REQ-012 SHALL have port out_data  output  OUT_W  extended result.
REQ-013 SHALL have port out_err  output  1  result came from an illegal mode.

Function
REQ-014 Transfer occurs on in_valid&in_ready (push) and out_valid&out_ready (pop), both sampled at rising clk.
REQ-015 Mode 0 ZERO: out = in_data zero-extended to OUT_W.
REQ-016 Mode 1 SIGN: out = in_data with bit IN_W-1 replicated into bits OUT_W-1..IN_W.
REQ-017 Mode 2 UPPER: out = in_data placed in bits OUT_W-1..OUT_W-IN_W, low bits zero (LUI form).
REQ-018 Mode 3 BYTE: out = in_data[7:0] with bit 7 replicated into bits OUT_W-1..8.
REQ-019 Extension SHALL be computed at push time and stored; buffered entries are unaffected by later in_mode changes.
REQ-020 Storage SHALL be a 2-entry FIFO (skid buffer); latency push-to-out_valid exactly 1 cycle.
REQ-021 in_ready SHALL be a registered signal, high iff fewer than 2 entries are stored.
REQ-022 With 1 entry, simultaneous push and pop SHALL keep count 1 and present the new entry next cycle.
REQ-023 With 2 entries, in_ready is low; a pop frees one slot and in_ready rises the following cycle.
REQ-024 Pop with 0 entries SHALL not occur (out_valid low); out_ready while empty is ignored.
REQ-025 out_data/out_err SHALL remain stable while out_valid&!out_ready.
REQ-026 flush SHALL empty the FIFO next cycle, override a simultaneous push, and drop that push.
REQ-027 FIFO pointers SHALL wrap modulo 2 with no loss or duplication over sustained full-rate traffic.

Reset
REQ-028 rst_n low SHALL immediately force out_valid=0, in_ready=0, count=0, pointers=0, out_data=0, out_err=0.
REQ-029 in_ready SHALL rise on the first clk edge after rst_n deasserts; entries in flight at reset are lost.

Configuration
REQ-030 Macro IMM_EXT_UPPER_EN defined: mode 2 behaves per REQ-017, out_err=0.
REQ-031 Macro IMM_EXT_UPPER_EN undefined: mode 2 is illegal; the entry is stored with out_data=0, out_err=1; all other modes unchanged.

Structure
REQ-032 Shared package imm_ext_pkg SHALL hold the mode encodings (ZERO=0, SIGN=1, UPPER=2, BYTE=3) and the FIFO depth constant 2.
REQ-033 Sub-module imm_ext_skid_fifo SHALL implement the parametrised-width 2-entry FIFO; extension logic lives in imm_ext_pipe.

Verification
REQ-034 SIGN, in_data=16'h8004, out_ready=1 -> next cycle out_valid=1, out_data=32'hFFFF8004.
REQ-035 ZERO 16'h8004 then BYTE 16'h0080 back-to-back -> 32'h00008004 then 32'hFFFFFF80, one per cycle.
REQ-036 UPPER 16'h1234: with IMM_EXT_UPPER_EN -> 32'h12340000, out_err=0; without -> 32'h0, out_err=1.
REQ-037 out_ready=0, push 3 items -> in_ready low after 2; raise out_ready -> items popped in order, third accepted after first pop.
REQ-038 FIFO full, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, pushed item never appears.
REQ-039 rst_n pulled low mid-stream asynchronously -> out_valid=0 before next clk edge; in_ready=1 one cycle after release.
